// File: rtl/life_pkg.sv
// Shared Game-of-Life definitions: generation FSM state encoding and board
// geometry defaults, also used by Block_Mem and Display.
package life_pkg;

  localparam int LIFE_NUM_BLOCKS = 4;
  localparam int LIFE_POS_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_ADDR       = 3'd2,
    ST_LOAD       = 3'd3,
    ST_RUN        = 3'd4,
    ST_STORE      = 3'd5,
    ST_DONE       = 3'd6
  } life_state_e;

endpackage

// File: rtl/life_req_latch.sv
// Generation request latch: holds one pending request, flags dropped requests
// as a sticky overrun, and (with LIFE_SINGLE_STEP_EN) turns a rising edge of
// step into a request while the board is paused.
module life_req_latch (
  input  logic clk,
  input  logic reset,
`ifdef LIFE_SINGLE_STEP_EN
  input  logic step,
`endif
  input  logic enb,
  input  logic trigger,
  input  logic consume,
  output logic req,
  output logic overrun
);

  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic new_req;

`ifdef LIFE_SINGLE_STEP_EN
  logic step_q, step_d;

  // Single-step only counts while paused; running boards ignore it.
  always_comb begin
    step_d  = step;
    new_req = (trigger & enb) | (step & ~step_q & ~enb);
  end

  // Step history for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step_d;
  end
`else
  // Only the rate tick can request a generation.
  always_comb new_req = trigger & enb;
`endif

  // A fresh request can be consumed in the same cycle it arrives, so the FSM
  // sees pending_q or the incoming one. A request landing on a held one is lost.
  always_comb begin
    req       = pending_q | new_req;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (new_req && pending_q) overrun_d = 1'b1;
    if (consume)              pending_d = 1'b0;
    else if (new_req)         pending_d = 1'b1;
  end

  // Request state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: rtl/life_gen_sequencer.sv
// Game-of-Life generation sequencer: walks every 4x4 tile in block memory
// (address, load, step, write back) once per generation, starting only at a
// frame boundary after a rate tick. Optional macro LIFE_SINGLE_STEP_EN adds a
// step input for manual single generations while paused.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int NUM_BLOCKS = LIFE_NUM_BLOCKS,
  parameter int POS_W      = LIFE_POS_W,
  parameter int READ_LAT   = 2,
  parameter int GEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             trigger,
  input  logic             frame,
`ifdef LIFE_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [POS_W-1:0] pos,
  output logic             write_array,
  output logic             run,
  output logic             write_mem,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             overrun
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  life_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             write_array_q, write_array_d;
  logic             run_q, run_d;
  logic             write_mem_q, write_mem_d;
  logic             busy_q, busy_d;
  logic             consume, req;

  life_req_latch u_req (
    .clk     (clk),
    .reset   (reset),
`ifdef LIFE_SINGLE_STEP_EN
    .step    (step),
`endif
    .enb     (enb),
    .trigger (trigger),
    .consume (consume),
    .req     (req),
    .overrun (overrun)
  );

  // Next-state and registered-output decode; strobes follow the next state so
  // each is high exactly while the FSM sits in its state.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    lat_cnt_d   = lat_cnt_q;
    gen_count_d = gen_count_q;
    consume     = 1'b0;
    case (state_q)
      ST_IDLE: if (req) begin
        state_d = ST_WAIT_FRAME;
        consume = 1'b1;
      end
      ST_WAIT_FRAME: if (frame) begin
        state_d   = ST_ADDR;
        pos_d     = '0;
        lat_cnt_d = '0;
      end
      ST_ADDR: begin
        if (lat_cnt_q == LAT_W'(READ_LAT - 1)) state_d = ST_LOAD;
        else                                   lat_cnt_d = lat_cnt_q + 1'b1;
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  state_d = ST_STORE;
      ST_STORE: begin
        if (pos_q == POS_W'(NUM_BLOCKS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_ADDR;
          pos_d     = pos_q + 1'b1;
          lat_cnt_d = '0;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        gen_count_d = gen_count_q + 1'b1;
        pos_d       = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    write_array_d = (state_d == ST_LOAD);
    run_d         = (state_d == ST_RUN);
    write_mem_d   = (state_d == ST_STORE);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any partial generation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pos_q         <= '0;
      lat_cnt_q     <= '0;
      gen_count_q   <= '0;
      write_array_q <= 1'b0;
      run_q         <= 1'b0;
      write_mem_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      lat_cnt_q     <= lat_cnt_d;
      gen_count_q   <= gen_count_d;
      write_array_q <= write_array_d;
      run_q         <= run_d;
      write_mem_q   <= write_mem_d;
      busy_q        <= busy_d;
    end
  end

  assign pos         = pos_q;
  assign write_array = write_array_q;
  assign run         = run_q;
  assign write_mem   = write_mem_q;
  assign busy        = busy_q;
  assign gen_count   = gen_count_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: table of opening cycles, directed corner
// sequences, then random traffic against a timeline model of a generation.
module tb_life_gen_sequencer;

  localparam int NB    = 4;
  localparam int PW    = 2;
  localparam int RL    = 2;
  localparam int GW    = 4;   // narrow counter so wrap-around is reachable
  localparam int TILE  = RL + 3;
  localparam int TOTAL = NB * TILE;
`ifdef LIFE_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0, enb = 1'b0, trigger = 1'b0, frame = 1'b0, step = 1'b0;
  logic [PW-1:0] pos;
  logic          write_array, run, write_mem, busy, overrun;
  logic [GW-1:0] gen_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  life_gen_sequencer #(.NUM_BLOCKS(NB), .POS_W(PW), .READ_LAT(RL), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .enb(enb), .trigger(trigger), .frame(frame),
`ifdef LIFE_SINGLE_STEP_EN
    .step(step),
`endif
    .pos(pos), .write_array(write_array), .run(run), .write_mem(write_mem),
    .busy(busy), .gen_count(gen_count), .overrun(overrun)
  );

  // Reference: mode 0 idle, 1 waiting for frame, 2 k cycles into the tile walk, 3 done.
  int m_mode = 0, m_k = 0, m_gen = 0;
  bit m_pend = 0, m_ovr = 0, m_sprev = 0;

  task automatic model_step(input bit r, input bit e, input bit t, input bit f);
    bit rise, nr, cons;
    if (!r) begin
      m_mode = 0; m_k = 0; m_gen = 0; m_pend = 0; m_ovr = 0; m_sprev = 0;
      return;
    end
    rise    = step && !m_sprev;
    m_sprev = step;
    nr      = (t && e) || (STEP_EN && rise && !e);
    cons    = (m_mode == 0) && (m_pend || nr);
    if (nr && m_pend) m_ovr = 1;
    m_pend = cons ? 1'b0 : (nr ? 1'b1 : m_pend);
    case (m_mode)
      0: if (cons) m_mode = 1;
      1: if (f) begin m_mode = 2; m_k = 0; end
      2: if (m_k == TOTAL - 1) m_mode = 3; else m_k++;
      default: begin m_gen = (m_gen + 1) % (1 << GW); m_mode = 0; end
    endcase
  endtask

  function automatic logic [31:0] pack(input bit b, input int p, input bit wa, input bit rn,
                                       input bit wm, input bit ov, input int g);
    logic [PW-1:0] pp;
    logic [GW-1:0] gg;
    pp = PW'(p);
    gg = GW'(g);
    return 32'({b, pp, wa, rn, wm, ov, gg});
  endfunction

  function automatic logic [31:0] model_exp();
    int tile, ph;
    tile = m_k / TILE;
    ph   = m_k % TILE;
    case (m_mode)
      2:       return pack(1, tile, ph == RL, ph == RL + 1, ph == RL + 2, m_ovr, m_gen);
      3:       return pack(1, NB - 1, 0, 0, 0, m_ovr, m_gen);
      1:       return pack(1, 0, 0, 0, 0, m_ovr, m_gen);
      default: return pack(0, 0, 0, 0, 0, m_ovr, m_gen);
    endcase
  endfunction

  function automatic logic [31:0] dut_got();
    return 32'({busy, pos, write_array, run, write_mem, overrun, gen_count});
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance model, sample 1 time unit after posedge.
  task automatic cyc(input bit r, input bit e, input bit t, input bit f, input bit s);
    @(negedge clk);
    reset = r; enb = e; trigger = t; frame = f; step = s;
    model_step(r, e, t, f);
    @(posedge clk);
    #1;
    chk("model", dut_got(), model_exp());
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    for (i = 0; i < budget && busy; i++) cyc(1, enb, 0, 0, step);
    if (busy) chk({nm, "_timeout"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit r, e, t, f;
    bit busy; int pos; bit wa, rn, wm;
  } vec_t;

  vec_t tbl[12];
  int   wa_idx[$];
  int   n_run, n_wm, fall;
  int   g0;

  initial begin
    // Opening trace; a frame in the cycle that enters WAIT_FRAME is ignored.
    tbl[0]  = '{0,1,0,0, 0,0,0,0,0};
    tbl[1]  = '{1,1,0,0, 0,0,0,0,0};
    tbl[2]  = '{1,1,1,1, 1,0,0,0,0};
    tbl[3]  = '{1,1,0,0, 1,0,0,0,0};
    tbl[4]  = '{1,1,0,1, 1,0,0,0,0};
    tbl[5]  = '{1,1,0,0, 1,0,0,0,0};
    tbl[6]  = '{1,1,0,0, 1,0,1,0,0};
    tbl[7]  = '{1,1,0,0, 1,0,0,1,0};
    tbl[8]  = '{1,1,0,0, 1,0,0,0,1};
    tbl[9]  = '{1,1,0,0, 1,1,0,0,0};
    tbl[10] = '{1,1,0,0, 1,1,0,0,0};
    tbl[11] = '{1,1,0,0, 1,1,1,0,0};
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].f, 0);
      chk($sformatf("table%0d", i), dut_got(),
          pack(tbl[i].busy, tbl[i].pos, tbl[i].wa, tbl[i].rn, tbl[i].wm, 0, 0));
    end
    wait_idle(40, "table_end");
    chk("table_gen", 32'(gen_count), 32'd1);

    // Full generation: busy one cycle after trigger, frame 10 cycles later.
    g0 = m_gen;
    cyc(1, 1, 1, 0, 0);
    chk("busy_rise", 32'(busy), 32'd1);
    repeat (9) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    n_run = 0; n_wm = 0; fall = -1;
    for (int i = 1; i <= 40 && fall < 0; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (write_array) wa_idx.push_back(i);
      if (run) n_run++;
      if (write_mem) n_wm++;
      if (!busy) fall = i;
    end
    chk("wa_count", 32'(wa_idx.size()), 32'd4);
    chk("run_count", 32'(n_run), 32'd4);
    chk("wm_count", 32'(n_wm), 32'd4);
    if (wa_idx.size() == 4) chk("wa_spacing", 32'(wa_idx[3] - wa_idx[0]), 32'(3 * TILE));
    chk("done_latency", 32'(fall), 32'(TOTAL + 1));
    chk("gen_plus1", 32'(gen_count), 32'((g0 + 1) % (1 << GW)));

    // Paused: triggers and frames do nothing.
    g0 = m_gen;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, i % 3 == 0, i % 4 == 1, 0);
      chk("paused_busy", 32'(busy), 32'd0);
    end
    chk("paused_gen", 32'(gen_count), 32'(g0));

    // Reset, then two triggers during a busy generation.
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("first_trig_no_ovr", 32'(overrun), 32'd0);
    cyc(1, 1, 1, 0, 0);
    chk("second_trig_ovr", 32'(overrun), 32'd1);
    wait_idle(40, "ovr_gen1");
    cyc(1, 1, 0, 0, 0);
    chk("pending_restart", 32'(busy), 32'd1);
    cyc(1, 1, 0, 1, 0);
    wait_idle(40, "ovr_gen2");
    chk("ovr_gen2_count", 32'(gen_count), 32'd2);

    // Reset during STORE of tile 2.
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    for (int i = 0; i < 40 && !(write_mem && pos == 2); i++) cyc(1, 1, 0, 0, 0);
    chk("reach_store2", 32'({write_mem, pos}), 32'({1'b1, 2'd2}));
    cyc(0, 1, 0, 0, 0);
    chk("mid_reset", dut_got(), pack(0, 0, 0, 0, 0, 0, 0));

    // Counter wrap.
    for (int i = 0; i < 20 && gen_count != GW'((1 << GW) - 1); i++) begin
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 1, 0);
      wait_idle(40, "wrap_fill");
    end
    chk("wrap_full", 32'(gen_count), 32'((1 << GW) - 1));
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    wait_idle(40, "wrap_gen");
    chk("wrap_zero", 32'(gen_count), 32'd0);

`ifdef LIFE_SINGLE_STEP_EN
    // Single step while paused: one generation per rising edge only.
    g0 = m_gen;
    cyc(1, 0, 0, 0, 1);
    chk("step_busy", 32'(busy), 32'd1);
    cyc(1, 0, 0, 1, 1);
    wait_idle(40, "step_gen");
    chk("step_gen", 32'(gen_count), 32'((g0 + 1) % (1 << GW)));
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, i % 3 == 0, 1);
    chk("step_held", 32'({busy, gen_count}), 32'({1'b0, GW'((g0 + 1) % (1 << GW))}));
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("step_ignored_enb", 32'(busy), 32'd0);
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0 ? ~step : step);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
